// File: rtl/rnd_pkg.sv
// rnd_coord_gen shared types and constants: FSM states, SVGA bounds,
// candidate bit offset and a saturating counter helper.
package rnd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int SVGA_W  = 800;
    localparam int SVGA_H  = 600;
    localparam int Y_OFS   = 16;
    localparam int TRY_W   = 8;

    function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rnd_axis_lock.sv
// One axis of the coordinate sampler: compare, lock, hold.
// With RND_COORD_FALLBACK_EN an out-of-range candidate can be folded in.
module rnd_axis_lock
    import rnd_pkg::*;
#(
    parameter int W   = 10,
    parameter int MAX = SVGA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         frc,
    input  logic [W-1:0] cand,
    output logic         ok,
    output logic         ok_nxt,
    output logic [W-1:0] val
);

    localparam logic [W:0] LIM = (W+1)'(MAX);

    logic         hit;
    logic         take;
    logic [W-1:0] nv;

    assign hit = {1'b0, cand} < LIM;

`ifdef RND_COORD_FALLBACK_EN
    // Out-of-range candidates lie in [MAX, 2*MAX), so one subtract folds them.
    assign take = hit | frc;
    assign nv   = hit ? cand : cand - LIM[W-1:0];
`else
    logic unused_frc;
    assign unused_frc = frc;
    assign take       = hit;
    assign nv         = cand;
`endif

    assign ok_nxt = ok | take;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ok  <= 1'b0;
            val <= '0;
        end else if (clr) begin
            ok  <= 1'b0;
        end else if (en && !ok && take) begin
            ok  <= 1'b1;
            val <= nv;
        end
    end

endmodule

// File: rtl/rnd_coord_gen.sv
// Rejection-sampled spawn coordinate generator with valid/ready output.
// Optional try limit with fold-in fallback: RND_COORD_FALLBACK_EN.
module rnd_coord_gen
    import rnd_pkg::*;
#(
    parameter int X_MAX     = SVGA_W,
    parameter int Y_MAX     = SVGA_H,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int MAX_TRIES = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    rnd_i,
    input  logic           req_i,
    output logic           busy_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic [7:0]     tries_o
);

    localparam logic [8:0] TRY_LIM = 9'(MAX_TRIES);

    state_t     state;
    logic [7:0] try_cnt;
    logic [8:0] cnt_nx;
    logic       at_lim;
    logic       clr;
    logic       en;
    logic       x_ok, x_nxt;
    logic       y_ok, y_nxt;

    assign cnt_nx = {1'b0, try_cnt} + 9'd1;
    assign at_lim = cnt_nx >= TRY_LIM;
    assign clr    = (state == IDLE) && req_i;
    assign en     = (state == SAMPLE);

    rnd_axis_lock #(.W(X_W), .MAX(X_MAX)) u_x (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .frc    (at_lim),
        .cand   (rnd_i[X_W-1:0]),
        .ok     (x_ok),
        .ok_nxt (x_nxt),
        .val    (x_o)
    );

    rnd_axis_lock #(.W(Y_W), .MAX(Y_MAX)) u_y (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .frc    (at_lim),
        .cand   (rnd_i[Y_OFS+Y_W-1:Y_OFS]),
        .ok     (y_ok),
        .ok_nxt (y_nxt),
        .val    (y_o)
    );

    logic unused_ok;
    assign unused_ok = x_ok ^ y_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            try_cnt <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            tries_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        try_cnt <= '0;
                        busy_o  <= 1'b1;
                        state   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    try_cnt <= sat_inc(try_cnt);
                    if (x_nxt && y_nxt) begin
                        valid_o <= 1'b1;
                        tries_o <= sat_inc(try_cnt);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnd_coord_gen.sv
// Directed plus randomized bench for rnd_coord_gen against a
// first-in-range-word reference model.
module tb_rnd_coord_gen;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rnd_i;
    logic        req_i;
    logic        busy_o;
    logic        valid_o;
    logic        ready_i;
    logic [9:0]  x_o;
    logic [9:0]  y_o;
    logic [7:0]  tries_o;

    int vecs = 0;
    int miss = 0;

    logic [31:0] stim[$];
    int  m_x, m_y, m_n;
    bit  m_xok, m_yok;

    always #5 clk = ~clk;

    rnd_coord_gen #(.MAX_TRIES(MT)) dut (
        .clk     (clk),
        .rst     (rst),
        .rnd_i   (rnd_i),
        .req_i   (req_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .x_o     (x_o),
        .y_o     (y_o),
        .tries_o (tries_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the request edge.
    task automatic start_req();
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        chk("busy_after_req", busy_o, 1);
        chk("valid_after_req", valid_o, 0);
    endtask

    // Feeds one word per cycle; the model takes the first in-range value per axis.
    task automatic sample(input int max_cyc, input bit expect_done);
        logic [31:0] w;
        int cx, cy;
        m_xok = 0; m_yok = 0; m_n = 0;
        for (int i = 0; i < max_cyc; i++) begin
            w = (stim.size() != 0) ? stim.pop_front() : $urandom;
            rnd_i = w;
            @(negedge clk);
            m_n++;
            cx = int'(w[9:0]);
            cy = int'(w[25:16]);
            if (!m_xok && cx < 800) begin m_x = cx; m_xok = 1; end
            if (!m_yok && cy < 600) begin m_y = cy; m_yok = 1; end
`ifdef RND_COORD_FALLBACK_EN
            if (m_n >= MT) begin
                if (!m_xok) begin m_x = (cx >= 800) ? cx - 800 : cx; m_xok = 1; end
                if (!m_yok) begin m_y = (cy >= 600) ? cy - 600 : cy; m_yok = 1; end
            end
`endif
            chk("valid_per_cycle", valid_o, (m_xok && m_yok) ? 1 : 0);
            chk("busy_per_cycle", busy_o, 1);
            if (m_xok && m_yok) break;
        end
        stim.delete();
        if (expect_done && !(m_xok && m_yok))
            chk("done_in_budget", 0, 1);
        if (m_xok && m_yok) begin
            chk("x_value", x_o, m_x);
            chk("y_value", y_o, m_y);
            chk("tries_value", tries_o, (m_n > 255) ? 255 : m_n);
        end
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("valid_after_hs", valid_o, 0);
        chk("busy_after_hs", busy_o, 0);
    endtask

    initial begin
        rst = 1'b0; req_i = 1'b1; ready_i = 1'b0; rnd_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_x", x_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_tries", tries_o, 0);
        rst = 1'b1; req_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_pulse", busy_o, 0);

        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("ready_idle_valid", valid_o, 0);
        chk("ready_idle_busy", busy_o, 0);

        // basic: both in range on the first sample
        start_req();
        stim.push_back(32'h0064_00C8);
        sample(4, 1);
        chk("basic_x", x_o, 200);
        chk("basic_y", y_o, 100);
        chk("basic_tries", tries_o, 1);
        handshake();

        // y locks first and is not overwritten
        start_req();
        stim.push_back(32'h0010_03FF);
        stim.push_back(32'h0200_0005);
        sample(4, 1);
        chk("lock_x", x_o, 5);
        chk("lock_y", y_o, 16);
        chk("lock_tries", tries_o, 2);
        handshake();

        // bounds: max-1 accepted
        start_req();
        stim.push_back(32'h0257_031F);
        sample(3, 1);
        chk("bound_x", x_o, 799);
        chk("bound_y", y_o, 599);
        handshake();

        // bounds: max rejected, then accepted
        start_req();
        stim.push_back(32'h0258_0320);
        stim.push_back(32'h0001_0001);
        sample(4, 1);
        chk("rej_tries", tries_o, 2);

        // backpressure with stray requests
        for (int i = 0; i < 10; i++) begin
            rnd_i = $urandom;
            req_i = i[0];
            @(negedge clk);
            chk("bp_valid", valid_o, 1);
            chk("bp_busy", busy_o, 1);
            chk("bp_x", x_o, m_x);
            chk("bp_y", y_o, m_y);
            chk("bp_tries", tries_o, m_n);
        end
        req_i = 1'b0;
        handshake();
        @(negedge clk);
        chk("dropped_req", busy_o, 0);

        // randomized transactions with random consumer stalls
        for (int t = 0; t < 25; t++) begin
            start_req();
            sample(200, 1);
            repeat ($urandom_range(0, 3)) begin
                rnd_i = $urandom;
                @(negedge clk);
                chk("rnd_hold_x", x_o, m_x);
                chk("rnd_hold_valid", valid_o, 1);
            end
            handshake();
        end

        // permanently out-of-range source
        start_req();
        for (int i = 0; i < 30; i++) stim.push_back(32'h03FF_03FF);
`ifdef RND_COORD_FALLBACK_EN
        sample(30, 1);
        chk("fb_x", x_o, 223);
        chk("fb_y", y_o, 423);
        chk("fb_tries", tries_o, MT);
        handshake();
`else
        sample(30, 0);
        chk("stuck_valid", valid_o, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
`endif

        // reset while a pair is waiting discards it
        start_req();
        stim.push_back(32'h0001_0002);
        sample(3, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstdone_valid", valid_o, 0);
        chk("rstdone_busy", busy_o, 0);
        chk("rstdone_x", x_o, 0);
        chk("rstdone_y", y_o, 0);
        chk("rstdone_tries", tries_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
